// File: rtl/bcd_counter_ctrl.sv
// rtl/bcd_counter_ctrl.sv - run/stop/preset sequencer for a 4-digit BCD counter (optional LAP_CAPTURE_EN)
module bcd_counter_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic        cmd_clear,
    input  logic        cmd_preset,
    input  logic [15:0] preset_value,
    input  logic [15:0] target_value,
    input  logic        stop_at_target,
    input  logic [15:0] count_in,
`ifdef LAP_CAPTURE_EN
    input  logic        cmd_lap,
    output logic [15:0] lap_value,
    output logic        lap_valid,
`endif
    output logic        ctr_load,
    output logic [15:0] ctr_load_value,
    output logic        running,
    output logic        alarm,
    output logic        tick,
    output logic        target_hit,
    output logic        rollover
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_ALARM   = 2'd2
    } state_t;

    localparam logic [15:0] DIV_MAX = 16'(PRESCALE - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic        match_q, match_d;
    logic        target_hit_q, target_hit_d;
    logic        rollover_q, rollover_d;
    logic        at_target;
    logic [15:0] preset_clamped;

    // Clamp every preset nibble to a legal BCD digit so the counter never sees A..F
    always_comb begin
        preset_clamped = preset_value;
        for (int i = 0; i < 4; i++) begin
            if (preset_value[i*4 +: 4] > 4'd9) begin
                preset_clamped[i*4 +: 4] = 4'd9;
            end
        end
    end

    // Next state, prescaler, counter drive and pulse generation
    always_comb begin
        state_d        = state_q;
        div_d          = 16'd0;
        tick           = 1'b0;
        ctr_load_value = count_in;
        at_target      = (count_in == target_value);
        match_d        = at_target;
        target_hit_d   = 1'b0;
        rollover_d     = 1'b0;

        if (cmd_clear || cmd_stop) begin
            state_d = ST_STOPPED;
        end else begin
            case (state_q)
                ST_STOPPED: if (cmd_start) state_d = ST_RUNNING;
                ST_RUNNING: if (stop_at_target && at_target) state_d = ST_ALARM;
                ST_ALARM:   state_d = ST_ALARM;
                default:    state_d = ST_STOPPED;
            endcase
        end

        // div only advances while staying in RUNNING; any entry restarts the period
        if (state_q == ST_RUNNING && state_d == ST_RUNNING) begin
            div_d = (div_q == DIV_MAX) ? 16'd0 : div_q + 16'd1;
        end

        tick = (state_q == ST_RUNNING) && (div_q == DIV_MAX) &&
               !cmd_clear && !cmd_preset && !cmd_stop &&
               !(stop_at_target && at_target);

        if (cmd_clear) begin
            ctr_load_value = 16'h0000;
        end else if (cmd_preset) begin
            ctr_load_value = preset_clamped;
        end

        // Match history is tracked in every state so a stale match never re-fires
        target_hit_d = (state_q == ST_RUNNING) && at_target && !match_q;
        rollover_d   = tick && (count_in == 16'h9999);
    end

    assign ctr_load   = ~tick;
    assign running    = (state_q == ST_RUNNING);
    assign alarm      = (state_q == ST_ALARM);
    assign target_hit = target_hit_q;
    assign rollover   = rollover_q;

    // State, prescaler and registered pulse flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_STOPPED;
            div_q        <= 16'd0;
            match_q      <= 1'b0;
            target_hit_q <= 1'b0;
            rollover_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            match_q      <= match_d;
            target_hit_q <= target_hit_d;
            rollover_q   <= rollover_d;
        end
    end

`ifdef LAP_CAPTURE_EN
    logic [15:0] lap_value_q, lap_value_d;
    logic        lap_valid_q, lap_valid_d;

    // Lap snapshot: clear wins, capture only while the count is live or frozen at target
    always_comb begin
        lap_value_d = lap_value_q;
        lap_valid_d = lap_valid_q;
        if (cmd_clear) begin
            lap_value_d = 16'h0000;
            lap_valid_d = 1'b0;
        end else if (cmd_lap && state_q != ST_STOPPED) begin
            lap_value_d = count_in;
            lap_valid_d = 1'b1;
        end
    end

    // Lap register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap_value_q <= 16'h0000;
            lap_valid_q <= 1'b0;
        end else begin
            lap_value_q <= lap_value_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_value = lap_value_q;
    assign lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// tb/tb_bcd_counter_ctrl.sv - directed self-checking bench for bcd_counter_ctrl
module tb_bcd_counter_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        cmd_clear = 1'b0;
    logic        cmd_preset = 1'b0;
    logic [15:0] preset_value = 16'h0000;
    logic [15:0] target_value = 16'h0012;
    logic        stop_at_target = 1'b0;

    logic [15:0] cnt0 = 16'h0000;
    logic [15:0] cnt1 = 16'h0000;
    logic        ld0, ld1, run0, run1, alarm0, alarm1, tick0, tick1;
    logic        hit0, hit1, roll0, roll1;
    logic [15:0] lv0, lv1;
    int          hits0 = 0;
    int          hits1 = 0;
    int          total = 0;
    int          bad = 0;

`ifdef LAP_CAPTURE_EN
    logic        cmd_lap = 1'b0;
    logic [15:0] lap_value0, lap_value1;
    logic        lap_valid0, lap_valid1;
`endif

    bcd_counter_ctrl #(.PRESCALE(4)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_clear(cmd_clear), .cmd_preset(cmd_preset), .preset_value(preset_value),
        .target_value(target_value), .stop_at_target(stop_at_target), .count_in(cnt0),
`ifdef LAP_CAPTURE_EN
        .cmd_lap(cmd_lap), .lap_value(lap_value0), .lap_valid(lap_valid0),
`endif
        .ctr_load(ld0), .ctr_load_value(lv0), .running(run0), .alarm(alarm0),
        .tick(tick0), .target_hit(hit0), .rollover(roll0)
    );

    bcd_counter_ctrl #(.PRESCALE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_clear(cmd_clear), .cmd_preset(cmd_preset), .preset_value(preset_value),
        .target_value(target_value), .stop_at_target(stop_at_target), .count_in(cnt1),
`ifdef LAP_CAPTURE_EN
        .cmd_lap(cmd_lap), .lap_value(lap_value1), .lap_valid(lap_valid1),
`endif
        .ctr_load(ld1), .ctr_load_value(lv1), .running(run1), .alarm(alarm1),
        .tick(tick1), .target_hit(hit1), .rollover(roll1)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
                else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Behavioural 4-digit BCD counters driven by the controllers
    always @(posedge clk) begin
        cnt0 <= ld0 ? lv0 : bcd_inc(cnt0);
        cnt1 <= ld1 ? lv1 : bcd_inc(cnt1);
    end

    always @(negedge clk) begin
        hits0 <= hits0 + int'(hit0);
        hits1 <= hits1 + int'(hit1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_reset;
        #2;
        total++; if (run0 !== 1'b0) begin bad++; $display("FAIL reset_running got %b want 0", run0); end
        total++; if (alarm0 !== 1'b0) begin bad++; $display("FAIL reset_alarm got %b want 0", alarm0); end
        total++; if (tick0 !== 1'b0) begin bad++; $display("FAIL reset_tick got %b want 0", tick0); end
        total++; if (ld0 !== 1'b1) begin bad++; $display("FAIL reset_load got %b want 1", ld0); end
        total++; if (lv0 !== 16'h0000) begin bad++; $display("FAIL reset_load_value got %h want 0000", lv0); end
        total++; if ({hit0, roll0} !== 2'b00) begin bad++; $display("FAIL reset_pulses got %b want 00", {hit0, roll0}); end
`ifdef LAP_CAPTURE_EN
        total++; if ({lap_valid0, lap_value0} !== 17'h0) begin bad++; $display("FAIL reset_lap got %h want 0", {lap_valid0, lap_value0}); end
`endif
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_basic_run;
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            total++;
            if (tick0 !== ((i % 4) == 0)) begin
                bad++; $display("FAIL run_tick cycle %0d got %b want %b", i, tick0, (i % 4) == 0);
            end
            cyc(1);
        end
        total++; if (cnt0 !== 16'h0010) begin bad++; $display("FAIL run_count got %h want 0010", cnt0); end
        total++; if (run0 !== 1'b1) begin bad++; $display("FAIL run_running got %b want 1", run0); end
    endtask

    task automatic test_stop_restart;
        int i;
        cmd_clear = 1'b1;
        #1;
        total++; if (lv0 !== 16'h0000) begin bad++; $display("FAIL clear_value got %h want 0000", lv0); end
        cyc(1);
        cmd_clear = 1'b0;
        total++; if ({run0, cnt0} !== 17'h0) begin bad++; $display("FAIL clear_state got %h want 0", {run0, cnt0}); end
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        for (i = 0; i < 100 && cnt0 !== 16'h0007; i++) cyc(1);
        total++; if (cnt0 !== 16'h0007) begin bad++; $display("FAIL reach_7 timeout got %h want 0007", cnt0); end
        cmd_stop = 1'b1;
        cyc(1);
        cmd_stop = 1'b0;
        cyc(20);
        total++; if ({run0, cnt0} !== {1'b0, 16'h0007}) begin bad++; $display("FAIL hold_7 got %h want 00007", {run0, cnt0}); end
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        cyc(3);
        total++; if ({tick0, cnt0} !== {1'b1, 16'h0007}) begin bad++; $display("FAIL restart_tick got %h want 10007", {tick0, cnt0}); end
        cyc(1);
        total++; if (cnt0 !== 16'h0008) begin bad++; $display("FAIL restart_count got %h want 0008", cnt0); end
        cyc(3);
        cmd_stop = 1'b1;
        #1;
        total++; if ({tick0, ld0} !== 2'b01) begin bad++; $display("FAIL stop_in_tick got %b want 01", {tick0, ld0}); end
        cyc(1);
        cmd_stop = 1'b0;
        total++; if ({run0, cnt0} !== {1'b0, 16'h0008}) begin bad++; $display("FAIL stop_hold got %h want 00008", {run0, cnt0}); end
    endtask

    task automatic test_stop_at_target;
        int i;
        int h;
        cmd_clear = 1'b1;
        cyc(1);
        cmd_clear = 1'b0;
        target_value = 16'h0012;
        stop_at_target = 1'b1;
        h = hits0;
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        for (i = 0; i < 200 && cnt0 !== 16'h0012; i++) cyc(1);
        total++; if (cnt0 !== 16'h0012) begin bad++; $display("FAIL reach_target timeout got %h want 0012", cnt0); end
        total++; if ({alarm0, hit0, tick0} !== 3'b000) begin bad++; $display("FAIL at_target_cycle got %b want 000", {alarm0, hit0, tick0}); end
        cyc(1);
        total++; if ({alarm0, hit0, run0} !== 3'b110) begin bad++; $display("FAIL alarm_rise got %b want 110", {alarm0, hit0, run0}); end
        cyc(10);
        total++; if ({alarm0, cnt0} !== {1'b1, 16'h0012}) begin bad++; $display("FAIL frozen got %h want 10012", {alarm0, cnt0}); end
        total++; if (hits0 - h !== 1) begin bad++; $display("FAIL hit_once got %0d want 1", hits0 - h); end
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        cyc(3);
        total++; if ({alarm0, run0, cnt0} !== {2'b10, 16'h0012}) begin bad++; $display("FAIL start_ignored got %h want 20012", {alarm0, run0, cnt0}); end
        cmd_stop = 1'b1;
        cyc(1);
        cmd_stop = 1'b0;
        total++; if ({alarm0, run0} !== 2'b00) begin bad++; $display("FAIL alarm_stop got %b want 00", {alarm0, run0}); end
    endtask

    task automatic test_preset_wrap;
        int h;
        stop_at_target = 1'b0;
        target_value = 16'h0012;
        preset_value = 16'h9998;
        cmd_preset = 1'b1;
        #1;
        total++; if (lv1 !== 16'h9998) begin bad++; $display("FAIL preset_value got %h want 9998", lv1); end
        cyc(1);
        cmd_preset = 1'b0;
        total++; if ({run1, cnt1} !== {1'b0, 16'h9998}) begin bad++; $display("FAIL preset_load got %h want 09998", {run1, cnt1}); end
        h = hits1;
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        total++; if ({tick1, cnt1} !== {1'b1, 16'h9998}) begin bad++; $display("FAIL p1_first_tick got %h want 19998", {tick1, cnt1}); end
        cyc(1);
        total++; if ({roll1, cnt1} !== {1'b0, 16'h9999}) begin bad++; $display("FAIL at_9999 got %h want 09999", {roll1, cnt1}); end
        cyc(1);
        total++; if ({roll1, cnt1} !== {1'b1, 16'h0000}) begin bad++; $display("FAIL wrap got %h want 10000", {roll1, cnt1}); end
        cyc(1);
        total++; if ({roll1, cnt1} !== {1'b0, 16'h0001}) begin bad++; $display("FAIL after_wrap got %h want 00001", {roll1, cnt1}); end
        cmd_stop = 1'b1;
        cyc(1);
        cmd_stop = 1'b0;
        total++; if (hits1 - h !== 0) begin bad++; $display("FAIL no_hit_wrap got %0d want 0", hits1 - h); end
    endtask

    task automatic test_preset_clamp;
        preset_value = 16'h1A3F;
        cmd_preset = 1'b1;
        #1;
        total++; if (lv0 !== 16'h1939) begin bad++; $display("FAIL clamp_value got %h want 1939", lv0); end
        cyc(1);
        cmd_preset = 1'b0;
        total++; if ({run0, cnt0} !== {1'b0, 16'h1939}) begin bad++; $display("FAIL clamp_count got %h want 01939", {run0, cnt0}); end
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        cyc(2);
        preset_value = 16'h5555;
        cmd_preset = 1'b1;
        cmd_clear = 1'b1;
        #1;
        total++; if ({tick0, lv0} !== 17'h0) begin bad++; $display("FAIL clear_over_preset got %h want 0", {tick0, lv0}); end
        cyc(1);
        cmd_preset = 1'b0;
        cmd_clear = 1'b0;
        total++; if ({run0, cnt0} !== 17'h0) begin bad++; $display("FAIL clear_preset_state got %h want 0", {run0, cnt0}); end
        cmd_start = 1'b1;
        cmd_stop = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        cmd_stop = 1'b0;
        total++; if (run0 !== 1'b0) begin bad++; $display("FAIL start_stop_together got %b want 0", run0); end
    endtask

    task automatic test_reset_mid_run;
        logic [15:0] c;
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        cyc(6);
        total++; if (run0 !== 1'b1) begin bad++; $display("FAIL pre_reset_running got %b want 1", run0); end
        reset_n = 1'b0;
        #1;
        total++; if ({run0, alarm0, tick0, ld0, hit0, roll0} !== 6'b000100) begin
            bad++; $display("FAIL reset_async got %b want 000100", {run0, alarm0, tick0, ld0, hit0, roll0});
        end
        c = cnt0;
        cyc(3);
        total++; if (cnt0 !== c) begin bad++; $display("FAIL reset_freeze got %h want %h", cnt0, c); end
        reset_n = 1'b1;
        cyc(5);
        total++; if ({run0, cnt0} !== {1'b0, c}) begin bad++; $display("FAIL post_reset got %h want %h", {run0, cnt0}, {1'b0, c}); end
    endtask

`ifdef LAP_CAPTURE_EN
    task automatic test_lap;
        int i;
        cmd_clear = 1'b1;
        cyc(1);
        cmd_clear = 1'b0;
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        for (i = 0; i < 400 && cnt0 !== 16'h0042; i++) cyc(1);
        total++; if (cnt0 !== 16'h0042) begin bad++; $display("FAIL reach_42 timeout got %h want 0042", cnt0); end
        cmd_lap = 1'b1;
        cyc(1);
        cmd_lap = 1'b0;
        total++; if ({lap_valid0, lap_value0, run0} !== {1'b1, 16'h0042, 1'b1}) begin
            bad++; $display("FAIL lap_capture got %h want %h", {lap_valid0, lap_value0, run0}, {1'b1, 16'h0042, 1'b1});
        end
        cmd_clear = 1'b1;
        cyc(1);
        cmd_clear = 1'b0;
        total++; if ({lap_valid0, lap_value0} !== 17'h0) begin bad++; $display("FAIL lap_clear got %h want 0", {lap_valid0, lap_value0}); end
        cmd_lap = 1'b1;
        cyc(1);
        cmd_lap = 1'b0;
        total++; if (lap_valid0 !== 1'b0) begin bad++; $display("FAIL lap_stopped got %b want 0", lap_valid0); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_run();
        test_stop_restart();
        test_stop_at_target();
        test_preset_wrap();
        test_preset_clamp();
        test_reset_mid_run();
`ifdef LAP_CAPTURE_EN
        test_lap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
